// File: rtl/tank_health_pkg.sv
// Shared definitions for the tank health block and the bullet block.
// Holds the health state encoding, sprite geometry and the explosion stage helper.
package tank_pkg;

  typedef enum logic [1:0] {
    ALIVE  = 2'd0,
    INVULN = 2'd1,
    DYING  = 2'd2,
    DEAD   = 2'd3
  } health_state_t;

  localparam int TANK_SIZE   = 16;
  localparam int BULLET_SIZE = 2;
  localparam int MAX_BULLETS = 4;

  localparam int HP_W    = 3;
  localparam int FRAME_W = 8;

  // Explosion sprite stage: count*4/frames, always 0..3 while count < frames.
  function automatic logic [1:0] explode_stage(input logic [FRAME_W-1:0] cnt,
                                               input int frames);
    logic [FRAME_W+1:0] scaled;
    scaled = {cnt, 2'b00} / (FRAME_W+2)'(frames);
    return scaled[1:0];
  endfunction

endpackage

// File: rtl/tank_health_if.sv
// Signal bundle between the game logic and the tank health block.
// hit is a level sampled every cycle; frame_tick and restart are one-cycle pulses.
interface tank_health_if;
  import tank_pkg::*;

  logic                hit;
  logic                frame_tick;
  logic                restart;
  logic [HP_W-1:0]     hp;
  health_state_t       state;
  logic                hit_taken;
  logic                visible;
  logic [1:0]          explode_idx;
  logic                game_over;

  modport master (
    output hit, frame_tick, restart,
    input  hp, state, hit_taken, visible, explode_idx, game_over
  );

  modport slave (
    input  hit, frame_tick, restart,
    output hp, state, hit_taken, visible, explode_idx, game_over
  );

endinterface

// File: rtl/tank_health_frame_timer.sv
// 8-bit frame counter with synchronous clear and terminal-count detect.
// Terminal count returns the counter to zero so the owner never sees a wrap.
module frame_timer
  import tank_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               enable,
  input  logic               tick,
  input  logic [FRAME_W-1:0] terminal,
  output logic [FRAME_W-1:0] count_next,
  output logic               at_terminal
);

  logic [FRAME_W-1:0] count_q;
  logic [FRAME_W-1:0] count_d;

  always_comb begin
    at_terminal = 1'b0;
    count_d     = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && tick) begin
      if (count_q == terminal) begin
        at_terminal = 1'b1;
        count_d     = '0;
      end else begin
        count_d = count_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_next = count_d;

endmodule

// File: rtl/tank_health.sv
// Tank hit-point FSM: ALIVE -> INVULN after a survivable hit, ALIVE -> DYING -> DEAD
// after the last hit point; all outputs come straight from flops.
module tank_health
  import tank_pkg::*;
#(
  parameter int MAX_HP         = 3,
  parameter int INVULN_FRAMES  = 60,
  parameter int EXPLODE_FRAMES = 32,
  parameter int BLINK_SHIFT    = 2
) (
  input  logic         clk,
  input  logic         reset,
  tank_health_if.slave bus
);

  health_state_t      state_q, state_d;
  logic [HP_W-1:0]    hp_q, hp_d;
  logic               hit_taken_q, hit_taken_d;
  logic               visible_q, visible_d;
  logic [1:0]         explode_idx_q, explode_idx_d;
  logic               game_over_q, game_over_d;

  logic               timer_clear;
  logic               timer_enable;
  logic [FRAME_W-1:0] timer_terminal;
  logic [FRAME_W-1:0] count_d;
  logic               timer_done;

  // The counter only runs in the two timed states; ALIVE holds it at zero so a
  // frame_tick arriving with the entering hit is never counted.
  always_comb begin
    timer_enable   = (state_q == INVULN) || (state_q == DYING);
    timer_clear    = bus.restart || !timer_enable;
    timer_terminal = (state_q == INVULN) ? FRAME_W'(INVULN_FRAMES - 1)
                                         : FRAME_W'(EXPLODE_FRAMES - 1);
  end

  frame_timer u_frame_timer (
    .clk         (clk),
    .reset       (reset),
    .clear       (timer_clear),
    .enable      (timer_enable),
    .tick        (bus.frame_tick),
    .terminal    (timer_terminal),
    .count_next  (count_d),
    .at_terminal (timer_done)
  );

  always_comb begin
    state_d     = state_q;
    hp_d        = hp_q;
    hit_taken_d = 1'b0;
    if (bus.restart) begin
      state_d = ALIVE;
      hp_d    = HP_W'(MAX_HP);
    end else begin
      case (state_q)
        ALIVE: begin
          if (bus.hit) begin
            hit_taken_d = 1'b1;
            if (hp_q <= 3'd1) begin
              hp_d    = '0;
              state_d = DYING;
            end else begin
              hp_d    = hp_q - 3'd1;
              state_d = INVULN;
            end
          end
        end
        INVULN: begin
          if (timer_done) state_d = ALIVE;
        end
        DYING: begin
          if (timer_done) state_d = DEAD;
        end
        DEAD: begin
          hp_d = '0;
        end
        default: state_d = ALIVE;
      endcase
    end
  end

  // Sprite outputs are decoded from the next-state values so they register
  // alongside state and hp.
  always_comb begin
    visible_d     = 1'b0;
    explode_idx_d = 2'd0;
    game_over_d   = 1'b0;
    case (state_d)
      ALIVE:   visible_d = 1'b1;
      INVULN:  visible_d = ~count_d[BLINK_SHIFT];
      DYING:   explode_idx_d = explode_stage(count_d, EXPLODE_FRAMES);
      DEAD:    game_over_d = 1'b1;
      default: visible_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ALIVE;
      hp_q          <= HP_W'(MAX_HP);
      hit_taken_q   <= 1'b0;
      visible_q     <= 1'b1;
      explode_idx_q <= 2'd0;
      game_over_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      hp_q          <= hp_d;
      hit_taken_q   <= hit_taken_d;
      visible_q     <= visible_d;
      explode_idx_q <= explode_idx_d;
      game_over_q   <= game_over_d;
    end
  end

  assign bus.hp          = hp_q;
  assign bus.state       = state_q;
  assign bus.hit_taken   = hit_taken_q;
  assign bus.visible     = visible_q;
  assign bus.explode_idx = explode_idx_q;
  assign bus.game_over   = game_over_q;

endmodule
